// File: rtl/hdc_pkg.sv
// Shared types for the hyperdimensional compute datapath: element word and
// operand-loader state encoding.
package hdc_pkg;

    localparam int ELEM_W = 64;

    typedef logic [ELEM_W-1:0] hv_elem_t;

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        START,
        WAIT_DONE,
        DRAIN
    } loader_state_t;

endpackage : hdc_pkg

// File: rtl/hv_operand_loader.sv
// Streams one frame (A words then B words) into two operand buffers, kicks the
// downstream kernel with a start pulse and holds the operands until it is done.
module hv_operand_loader
    import hdc_pkg::*;
#(
    parameter int HYPERVECTOR_DIMENSIONS = 100
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ELEM_W-1:0] in_data,
    input  logic              in_last,
    output hv_elem_t          hvecA [0:HYPERVECTOR_DIMENSIONS-1],
    output hv_elem_t          hvecB [0:HYPERVECTOR_DIMENSIONS-1],
    output logic              start,
    input  logic              kernel_done,
    output logic              busy,
    output logic              frame_err
);

    localparam int IDX_W = $clog2(HYPERVECTOR_DIMENSIONS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HYPERVECTOR_DIMENSIONS - 1);

    loader_state_t  state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    hv_elem_t       hvec_a_q [0:HYPERVECTOR_DIMENSIONS-1];
    hv_elem_t       hvec_a_d [0:HYPERVECTOR_DIMENSIONS-1];
    hv_elem_t       hvec_b_q [0:HYPERVECTOR_DIMENSIONS-1];
    hv_elem_t       hvec_b_d [0:HYPERVECTOR_DIMENSIONS-1];
    logic           frame_err_q, frame_err_d;

    logic xfer;
    logic at_last_idx;

    assign in_ready    = (state_q == LOAD_A) || (state_q == LOAD_B) || (state_q == DRAIN);
    assign xfer        = in_valid && in_ready;
    assign at_last_idx = (idx_q == LAST_IDX);

    always_comb begin
        // NOTE: every variable gets its hold value first so no path can infer a latch.
        state_d     = state_q;
        idx_d       = idx_q;
        hvec_a_d    = hvec_a_q;
        hvec_b_d    = hvec_b_q;
        frame_err_d = 1'b0;

        unique case (state_q)
            LOAD_A: begin
                if (xfer) begin
                    if (in_last) begin
                        // A premature end of frame drops the word and restarts cleanly.
                        frame_err_d = 1'b1;
                        idx_d       = '0;
                    end else begin
                        hvec_a_d[idx_q] = in_data;
                        if (at_last_idx) begin
                            idx_d   = '0;
                            state_d = LOAD_B;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
            end
            LOAD_B: begin
                if (xfer) begin
                    if (at_last_idx) begin
                        hvec_b_d[idx_q] = in_data;
                        idx_d           = '0;
                        if (in_last) begin
                            state_d = START;
                        end else begin
                            // Frame overran: resynchronise on the next in_last.
                            frame_err_d = 1'b1;
                            state_d     = DRAIN;
                        end
                    end else if (in_last) begin
                        frame_err_d = 1'b1;
                        idx_d       = '0;
                        state_d     = LOAD_A;
                    end else begin
                        hvec_b_d[idx_q] = in_data;
                        idx_d           = idx_q + IDX_W'(1);
                    end
                end
            end
            START: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (kernel_done) begin
                    state_d = LOAD_A;
                end
            end
            DRAIN: begin
                if (xfer && in_last) begin
                    state_d = LOAD_A;
                end
            end
            default: begin
                state_d = LOAD_A;
                idx_d   = '0;
            end
        endcase
    end

    // NOTE: the operand buffers are reset too, so the kernel never sees X operands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= LOAD_A;
            idx_q       <= '0;
            frame_err_q <= 1'b0;
            for (int i = 0; i < HYPERVECTOR_DIMENSIONS; i++) begin
                hvec_a_q[i] <= '0;
                hvec_b_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            frame_err_q <= frame_err_d;
            hvec_a_q    <= hvec_a_d;
            hvec_b_q    <= hvec_b_d;
        end
    end

    assign hvecA     = hvec_a_q;
    assign hvecB     = hvec_b_q;
    assign start     = (state_q == START);
    assign frame_err = frame_err_q;
    assign busy      = !((state_q == LOAD_A) && (idx_q == '0));

endmodule : hv_operand_loader

// File: tb/tb_hv_operand_loader.sv
// Scoreboard bench for hv_operand_loader with four-element hypervectors.
module tb_hv_operand_loader;
    import hdc_pkg::*;

    localparam int D = 4;

    typedef struct packed {
        logic [D-1:0][ELEM_W-1:0] a;
        logic [D-1:0][ELEM_W-1:0] b;
    } frame_t;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            in_valid;
    logic            in_ready;
    logic [ELEM_W-1:0] in_data;
    logic            in_last;
    hv_elem_t        hvec_a [0:D-1];
    hv_elem_t        hvec_b [0:D-1];
    logic            start;
    logic            kernel_done;
    logic            busy;
    logic            frame_err;

    int checks   = 0;
    int failures = 0;
    int start_cnt = 0;
    int err_cnt   = 0;
    int frames_pushed = 0;
    frame_t sb_q[$];

    always #5 clk = ~clk;

    hv_operand_loader #(.HYPERVECTOR_DIMENSIONS(D)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .hvecA       (hvec_a),
        .hvecB       (hvec_b),
        .start       (start),
        .kernel_done (kernel_done),
        .busy        (busy),
        .frame_err   (frame_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Operands are compared against the scoreboard whenever the kernel is kicked.
    always @(negedge clk) begin
        if (frame_err === 1'b1) err_cnt++;
        if (start === 1'b1) begin
            start_cnt++;
            check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                frame_t f;
                f = sb_q.pop_front();
                for (int i = 0; i < D; i++) begin
                    check($sformatf("hvecA[%0d]", i), hvec_a[i], f.a[i]);
                    check($sformatf("hvecB[%0d]", i), hvec_b[i], f.b[i]);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge just after the word transferred.
    task automatic send_word(input logic [63:0] d, input logic last, input bit gaps);
        int budget;
        if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        budget   = 0;
        while (in_ready !== 1'b1 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 100) check("ready_timeout", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [D-1:0][63:0] a, input logic [D-1:0][63:0] b,
                              input bit gaps);
        frame_t f;
        f.a = a;
        f.b = b;
        sb_q.push_back(f);
        frames_pushed++;
        for (int i = 0; i < D; i++) send_word(a[i], 1'b0, gaps);
        for (int i = 0; i < D; i++) send_word(b[i], (i == D - 1), gaps);
        check("start_after_last", 64'(start), 64'd1);
    endtask

    task automatic kernel_pulse();
        kernel_done = 1'b1;
        @(negedge clk);
        kernel_done = 1'b0;
        check("ready_after_done", 64'(in_ready), 64'd1);
        check("idle_after_done", 64'(busy), 64'd0);
    endtask

    initial begin
        logic [D-1:0][63:0] a;
        logic [D-1:0][63:0] b;
        int s0, e0;

        reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; kernel_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_start", 64'(start), 64'd0);
        check("rst_err", 64'(frame_err), 64'd0);
        for (int i = 0; i < D; i++) begin
            check("rst_hvecA", hvec_a[i], 64'd0);
            check("rst_hvecB", hvec_b[i], 64'd0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 64'(in_ready), 64'd1);

        // Basic frame, back-to-back words.
        a = {64'd4, 64'd3, 64'd2, 64'd1};
        b = {64'd8, 64'd7, 64'd6, 64'd5};
        send_frame(a, b, 1'b0);
        check("busy_in_start", 64'(busy), 64'd1);
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("ready_low_wait", 64'(in_ready), 64'd0);
            check("start_one_cycle", 64'(start), 64'd0);
        end
        in_valid = 1'b0;
        kernel_pulse();

        // Same frame with random valid gaps.
        s0 = start_cnt;
        send_frame(a, b, 1'b1);
        @(negedge clk);
        kernel_pulse();
        check("gap_one_start", 64'(start_cnt - s0), 64'd1);

        // in_last on A[2]: frame error, A[2] keeps its old value.
        e0 = err_cnt;
        s0 = start_cnt;
        send_word(64'h10, 1'b0, 1'b0);
        send_word(64'h11, 1'b0, 1'b0);
        send_word(64'h12, 1'b1, 1'b0);
        check("early_last_err", 64'(frame_err), 64'd1);
        check("early_hvecA0", hvec_a[0], 64'h10);
        check("early_hvecA1", hvec_a[1], 64'h11);
        check("early_hvecA2", hvec_a[2], 64'd3);
        check("early_idle", 64'(busy), 64'd0);
        @(negedge clk);
        check("early_err_pulse", 64'(frame_err), 64'd0);
        a = {64'h24, 64'h23, 64'h22, 64'h21};
        b = {64'h28, 64'h27, 64'h26, 64'h25};
        send_frame(a, b, 1'b0);
        @(negedge clk);
        kernel_pulse();
        check("early_err_once", 64'(err_cnt - e0), 64'd1);

        // Missing in_last on B[3]: drain until the next in_last.
        e0 = err_cnt;
        s0 = start_cnt;
        for (int i = 0; i < D; i++) send_word(64'h31 + 64'(i), 1'b0, 1'b0);
        for (int i = 0; i < D; i++) send_word(64'h35 + 64'(i), 1'b0, 1'b0);
        check("overrun_err", 64'(frame_err), 64'd1);
        check("overrun_hvecB3", hvec_b[3], 64'h38);
        check("overrun_hvecA0", hvec_a[0], 64'h31);
        send_word(64'h40, 1'b0, 1'b0);
        send_word(64'h41, 1'b0, 1'b0);
        send_word(64'h42, 1'b1, 1'b0);
        check("drain_idle", 64'(busy), 64'd0);
        check("drain_ready", 64'(in_ready), 64'd1);
        check("drain_hvecB0", hvec_b[0], 64'h35);
        check("drain_err_once", 64'(err_cnt - e0), 64'd1);
        check("drain_no_start", 64'(start_cnt - s0), 64'd0);

        // kernel_done in LOAD_A is ignored; reset mid-B abandons the frame.
        s0 = start_cnt;
        e0 = err_cnt;
        kernel_done = 1'b1;
        @(negedge clk);
        kernel_done = 1'b0;
        check("done_ignored_ready", 64'(in_ready), 64'd1);
        check("done_ignored_idle", 64'(busy), 64'd0);
        for (int i = 0; i < D; i++) send_word(64'h50 + 64'(i), 1'b0, 1'b0);
        send_word(64'h54, 1'b0, 1'b0);
        send_word(64'h55, 1'b0, 1'b0);
        check("midB_busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_start", 64'(start), 64'd0);
        check("arst_err", 64'(frame_err), 64'd0);
        for (int i = 0; i < D; i++) begin
            check("arst_hvecA", hvec_a[i], 64'd0);
            check("arst_hvecB", hvec_b[i], 64'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("arst_ready", 64'(in_ready), 64'd1);
        check("arst_no_start", 64'(start_cnt - s0), 64'd0);
        check("arst_no_err", 64'(err_cnt - e0), 64'd0);

        // Long kernel: inputs refused and operands stable for 50 cycles.
        a = {64'h64, 64'h63, 64'h62, 64'h61};
        b = {64'h68, 64'h67, 64'h66, 64'h65};
        send_frame(a, b, 1'b0);
        in_valid = 1'b1;
        in_data  = 64'hDEAD;
        begin
            int ready_seen;
            int changed;
            ready_seen = 0;
            changed    = 0;
            repeat (50) begin
                @(negedge clk);
                if (in_ready !== 1'b0) ready_seen++;
                for (int i = 0; i < D; i++)
                    if (hvec_a[i] !== a[i] || hvec_b[i] !== b[i]) changed++;
            end
            check("wait_ready_low", 64'(ready_seen), 64'd0);
            check("wait_stable", 64'(changed), 64'd0);
        end
        in_valid = 1'b0;
        kernel_pulse();

        repeat (3) @(negedge clk);
        check("final_sb_empty", 64'(sb_q.size()), 64'd0);
        check("final_starts", 64'(start_cnt), 64'(frames_pushed));
        check("final_errs", 64'(err_cnt), 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule : tb_hv_operand_loader

// File: doc/hv_operand_loader.md
HV_OPERAND_LOADER -- requirements
Module: hv_operand_loader

Interface
REQ-001 SHALL have parameter HYPERVECTOR_DIMENSIONS, default 100, giving the number of elements per hypervector (minimum 2).
REQ-002 SHALL have localparam IDX_W = $clog2(HYPERVECTOR_DIMENSIONS), the element index width.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  the upstream word on in_data is valid.
REQ-006 in_ready  output  1  the loader accepts a word this cycle.
REQ-007 in_data  input  64  hypervector element word.
REQ-008 in_last  input  1  marks the final word of a frame.
REQ-009 hvecA  output  64 x HYPERVECTOR_DIMENSIONS  operand A array, indices [0:HYPERVECTOR_DIMENSIONS-1].
REQ-010 hvecB  output  64 x HYPERVECTOR_DIMENSIONS  operand B array, indices [0:HYPERVECTOR_DIMENSIONS-1].
REQ-011 start  output  1  one-cycle pulse telling the downstream kernel that its operands are ready.
REQ-012 kernel_done  input  1  the downstream kernel has finished with the operands.
REQ-013 busy  output  1  a frame is in progress or the kernel is pending.
REQ-014 frame_err  output  1  one-cycle pulse on a malformed frame.

Function
REQ-015 A transfer SHALL occur on any cycle in which in_valid and in_ready are both high; no other cycle changes the buffers or the index.
REQ-016 A frame SHALL be 2*HYPERVECTOR_DIMENSIONS words: A[0..D-1] first, then B[0..D-1], with in_last high only on B[D-1].
REQ-017 The block SHALL have the states LOAD_A, LOAD_B, START, WAIT_DONE and DRAIN.
REQ-018 in_ready SHALL be 1 in LOAD_A, LOAD_B and DRAIN, and 0 in START and WAIT_DONE, decoded from registered state only.
REQ-019 In LOAD_A, a transfer SHALL write in_data to hvecA[idx] and increment idx; a transfer at idx=D-1 SHALL reset idx to 0 and go to LOAD_B.
REQ-020 In LOAD_B, a transfer SHALL write in_data to hvecB[idx] and increment idx; a transfer at idx=D-1 with in_last=1 SHALL reset idx to 0 and go to START.
REQ-021 A LOAD_B transfer at idx=D-1 with in_last=0 SHALL write the word, pulse frame_err, reset idx to 0 and go to DRAIN.
REQ-022 A transfer with in_last=1 at any other position in LOAD_A or LOAD_B SHALL NOT write the word, SHALL pulse frame_err, reset idx to 0 and go to LOAD_A.
REQ-023 DRAIN SHALL discard words until a transfer with in_last=1, then go to LOAD_A; frame_err SHALL NOT pulse again while in DRAIN.
REQ-024 START SHALL assert start for exactly one cycle, the cycle after the final B transfer, then go to WAIT_DONE.
REQ-025 WAIT_DONE SHALL hold hvecA and hvecB stable and go to LOAD_A on the cycle kernel_done=1; kernel_done in any other state SHALL be ignored.
REQ-026 hvecA and hvecB SHALL never be cleared between frames; elements not yet rewritten keep their previous values.
REQ-027 busy SHALL equal NOT (state==LOAD_A AND idx==0).
REQ-028 The index counter SHALL never exceed D-1; the wrap to 0 occurs only as stated in REQ-019 to REQ-022.
REQ-029 Minimum frame-to-frame throughput SHALL be 2D+2 cycles plus the kernel latency.

Reset
REQ-030 Asserting reset_n low SHALL immediately set state to LOAD_A, idx to 0, every element of hvecA and hvecB to 0, and start, frame_err and busy to 0, with in_ready=1 after release.
REQ-031 Reset asserted mid-frame or in WAIT_DONE SHALL abandon the frame, with no start pulse or frame_err pulse emitted.

Structure
REQ-032 A shared package hdc_pkg SHALL hold ELEM_W=64, typedef hv_elem_t (logic [ELEM_W-1:0]) and the loader state enum.
REQ-033 No sub-module SHALL be used; the index counter and state machine SHALL be inline in hv_operand_loader.

Verification (bench uses HYPERVECTOR_DIMENSIONS=4)
REQ-034 Send A=1,2,3,4 and B=5,6,7,8 with in_last on 8 -> start pulses one cycle after the word 8 transfer; hvecA={1,2,3,4}, hvecB={5,6,7,8}; in_ready=0 until kernel_done.
REQ-035 Toggle in_valid randomly during a frame -> the same buffer contents as REQ-034 and exactly one start pulse.
REQ-036 Raise in_last on A[2] -> frame_err pulses once, hvecA[2] is unchanged, and the next well-formed frame loads correctly.
REQ-037 Send B[3] with in_last=0, then 3 words with in_last on the third -> frame_err pulses once, no start pulse, and the block returns to LOAD_A.
REQ-038 Pulse kernel_done during LOAD_A, then pull reset_n low mid-B -> kernel_done is ignored; after reset all outputs are 0 and no start pulse occurs.
REQ-039 Hold kernel_done low for 50 cycles in WAIT_DONE while driving in_valid=1 -> in_ready=0, the buffers are stable, and the block returns to LOAD_A the cycle after kernel_done=1.
